// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width for a WIDTH-bit operand (WIDTH >= 2).
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders and an OR for the carry.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = x ^ y;
    assign w_c1 = x & y;
    assign s    = w_s1 ^ ci;
    assign w_c2 = w_s1 & ci;
    assign co   = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial LSB-first adder with valid/ready handshakes on both sides.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output ovf.
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               w_s;
    logic               w_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic               r_ovf_sr;
    logic               r_ovf;
`endif

    full_adder_cell u_fa (
        .x  (r_a_sr[0]),
        .y  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // DONE spends its first cycle publishing sum_sr/carry to the output
    // registers, so out_valid rises WIDTH+1 cycles after the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_sum_sr    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf_sr    <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a_sr     <= a;
                        r_b_sr     <= b;
                        r_carry    <= cin;
                        r_cnt      <= '0;
                        r_sum_sr   <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf_sr <= r_carry ^ w_co;
`endif
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_sum       <= r_sum_sr;
                        r_cout      <= r_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf       <= r_ovf_sr;
`endif
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed self-checking bench for serial_adder_fsm (WIDTH=8).
module tb_serial_adder_fsm;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_adder_fsm #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the accept edge until out_valid is seen; -1 on timeout.
    task automatic wait_out_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (sum !== 8'h00) begin n_err++; $display("FAIL reset_sum got=%h exp=00", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", cout); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef SERIAL_ADDER_OVF_EN
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    endtask

    task automatic test_basic();
        int n;
        a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b exp=1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_shift got=%b exp=0", in_ready); end
        wait_out_valid(n);
        n_cmp++; if (n !== 9) begin n_err++; $display("FAIL basic_latency got=%0d exp=9", n); end
        n_cmp++; if (sum !== 8'h47) begin n_err++; $display("FAIL basic_sum got=%h exp=47", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL basic_cout got=%b exp=0", cout); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_done got=%b exp=0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_out_valid_drop got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_back got=%b exp=1", in_ready); end
        n_cmp++; if (sum !== 8'h47) begin n_err++; $display("FAIL basic_sum_hold got=%h exp=47", sum); end
    endtask

    task automatic test_carry();
        int n;
        a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        n_cmp++; if (sum !== 8'h00) begin n_err++; $display("FAIL carry_ff_sum got=%h exp=00", sum); end
        n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL carry_ff_cout got=%b exp=1", cout); end
`ifdef SERIAL_ADDER_OVF_EN
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL carry_ff_ovf got=%b exp=0", ovf); end
`endif
        tick();
        a = 8'h7F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        n_cmp++; if (sum !== 8'h80) begin n_err++; $display("FAIL carry_7f_sum got=%h exp=80", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL carry_7f_cout got=%b exp=0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL carry_7f_ovf got=%b exp=1", ovf); end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        a = 8'h3C; b = 8'h5A; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        n_cmp++; if (n !== 9) begin n_err++; $display("FAIL bp_latency got=%0d exp=9", n); end
        for (int i = 0; i < 5; i++) begin
            a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = i[0];
            n_cmp++; if (sum !== 8'h96) begin n_err++; $display("FAIL bp_sum_stable[%0d] got=%h exp=96", i, sum); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (sum !== 8'h96) begin n_err++; $display("FAIL bp_sum_end got=%h exp=96", sum); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got=%b exp=0", out_valid); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_no_accept got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        n_cmp++; if (sum !== 8'h00) begin n_err++; $display("FAIL rmid_sum got=%h exp=00", sum); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rmid_no_out_valid got=%0d exp=0", seen); end
        a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        n_cmp++; if (sum !== 8'h02) begin n_err++; $display("FAIL rmid_after_sum got=%h exp=02", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL rmid_after_cout got=%b exp=0", cout); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vc [3];
        logic [7:0] es [3];
        logic       ec [3];
        int n;
        int w;
        va = '{8'hC8, 8'h0F, 8'h55};
        vb = '{8'h64, 8'hF0, 8'h22};
        vc = '{1'b0, 1'b1, 1'b1};
        es = '{8'h2C, 8'h00, 8'h78};
        ec = '{1'b1, 1'b1, 1'b0};
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = va[k]; b = vb[k]; cin = vc[k];
            w = 0;
            while (in_ready !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, in_ready); end
            tick();
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept[%0d] got=%b exp=1", k, busy); end
            wait_out_valid(n);
            n_cmp++; if (n !== 9) begin n_err++; $display("FAIL b2b_latency[%0d] got=%0d exp=9", k, n); end
            n_cmp++; if (sum !== es[k]) begin n_err++; $display("FAIL b2b_sum[%0d] got=%h exp=%h", k, sum, es[k]); end
            n_cmp++; if (cout !== ec[k]) begin n_err++; $display("FAIL b2b_cout[%0d] got=%b exp=%b", k, cout, ec[k]); end
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
